io_uart_tx: RTL and testbench
=============================

// Module: io_uart_tx
// PURPOSE
//  Memory-mapped-by-convention UART transmitter that consumes the cpu's 32-bit io_out
//  register and serialises bytes as 8N1 on a single tx line. A toggle handshake on
//  io_out[8] requests a send. A status word is returned for wiring into cpu io_in,
//  so software can poll for acceptance, FIFO full/empty and busy.
//  Holds a small byte FIFO so software can queue bytes while a frame is on the wire.
// PARAMETERS
//  CLK_DIV     104  clock cycles per UART bit; legal range >= 2
//  FIFO_DEPTH  4    byte FIFO entries; power of two, >= 2
//  FIFO_AW     2    log2(FIFO_DEPTH)
// PORTS
//  clk     in   1   system clock, all state on rising edge
//  rstn    in   1   asynchronous active-low reset
//  io_out  in   32  cpu output register; [7:0] data byte, [8] request toggle, [31:9] ignored
//  status  out  32  to cpu io_in; [8] ack toggle, [9] fifo_full, [10] fifo_empty, [11] tx_busy, others 0
//  tx      out  1   serial line, idle high, registered
// BEHAVIOUR
//  Reset (async, rstn=0): tx=1, FSM=IDLE, FIFO flushed, ack toggle=0 -> status=32'h0000_0400.
//   Assertion mid-frame aborts the frame: tx forced to 1 immediately and queued bytes are lost.
//  Request: pending when io_out[8] != ack. io_out is same-clock, so no synchroniser is used.
//   Accept edge: pending and (!full or pop on same edge). On that edge, push io_out[7:0]
//   and set ack<=io_out[8].
//   Full with no pop: request stays pending; ack and io_out are unchanged. Nothing is dropped.
//   Software holds io_out stable until status[8]==io_out[8].
//   The data byte is sampled only on the accept edge.
//   io_out[31:9] and data changes without a toggle have no effect.
//  FIFO: circular, FIFO_AW-bit pointers, count 0..FIFO_DEPTH.
//   Simultaneous push+pop: count unchanged, legal even when full.
//   fifo_full = (count==FIFO_DEPTH). fifo_empty = (count==0).
//  FSM states: IDLE, START, DATA, STOP. Baud counter loads CLK_DIV-1 and decrements to 0.
//   Every bit lasts exactly CLK_DIV cycles.
//   IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shifter, set tx<=0 and go to START.
//   START: after CLK_DIV cycles, tx<=shifter[0] and go to DATA with bit index 0.
//   DATA: every CLK_DIV cycles, shift right and increment the index. After bit 7 has lasted
//     CLK_DIV cycles, tx<=1 and go to STOP. Bits are sent LSB first.
//   STOP: after CLK_DIV cycles, if the FIFO is non-empty, pop, tx<=0 and go to START with no idle gap.
//     Otherwise go to IDLE.
//  Timing: frame = 10*CLK_DIV cycles.
//   A byte accepted on edge A into an empty FIFO with the FSM in IDLE drives tx low after edge A+1.
//  tx_busy = (state != IDLE). Status bits are registered or derived from registers only.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4)
//  1. Reset release -> status==32'h0000_0400 and tx==1 held indefinitely with io_out=0.
//  2. io_out=32'h155 -> status[8]=1 after 1 edge. tx: 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0
//     for 4 cycles each, then 1 for 4 cycles. busy for 40 cycles, then status==32'h0000_0500.
//  3. Six back-to-back toggled bytes 0x01..0x06, each waiting for ack. 0x01 enters the shifter
//     and 0x02..0x05 fill the FIFO (status[9]=1). 0x06 stays pending until the first pop
//     (~40 cycles later). Six frames are sent with no idle gap between them.
//  4. Send 0xA5 twice by toggling only bit 8 -> two identical frames. Changing io_out[31:9]
//     or [7:0] without a toggle -> no frame.
//  5. rstn pulsed low 15 cycles into a frame with 2 bytes queued -> tx==1 asynchronously,
//     status==32'h0000_0400, and no frames follow after release.
//  6. A toggle arrives on the exact edge the STOP bit pops while the FIFO is full -> push and pop
//     on the same edge, count unchanged, no byte lost.

Source files
------------

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter fed from the cpu io_out register through a small byte FIFO.
// A toggle on io_out[8] requests a send; status reports ack, FIFO state and busy.
module io_uart_tx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] io_out,
  output logic [31:0] status,
  output logic        tx
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = FIFO_AW + 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [BW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shifter;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic               ack;

  logic fifo_full;
  logic fifo_empty;
  logic bit_end;
  logic pop;
  logic push;
  logic unused_ok;

  assign unused_ok  = ^io_out[31:9];
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign bit_end    = (baud_cnt == '0);

  // The FSM pops when idle, or when a stop bit ends with more bytes waiting.
  assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push = (io_out[8] != ack) && (!fifo_full || pop);

  assign status = {20'b0, (state != IDLE), fifo_empty, fifo_full, ack, 8'b0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
        ack    <= io_out[8];
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= io_out[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shifter <= mem[rd_ptr];
    end else if ((state == DATA) && bit_end && (bit_idx != 3'd7)) begin
      shifter <= {1'b0, shifter[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            tx       <= 1'b0;
            baud_cnt <= BAUD_LOAD;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx       <= shifter[0];
            bit_idx  <= '0;
            baud_cnt <= BAUD_LOAD;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // shifter[1] becomes shifter[0] on this same edge
              tx      <= shifter[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              tx       <= 1'b0;
              baud_cnt <= BAUD_LOAD;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
// A bit-level receiver decodes frames from tx and checks framing, gaps and busy time.
module tb_io_uart_tx;

  logic        clk;
  logic        rstn;
  logic [31:0] io_out;
  logic [31:0] status;
  logic        tx;

  int   n_vec = 0;
  int   n_err = 0;
  logic tog   = 1'b0;

  io_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_out (io_out),
    .status (status),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decodes one 40-cycle frame sampled on falling edges; gap = idle cycles before start.
  task automatic recv_frame(output logic [7:0] d, output int gap, output int busy, output bit ok);
    d = 8'h00; gap = 0; busy = 0; ok = 1'b1;
    @(negedge clk);
    while (tx !== 1'b0 && gap < 2000) begin
      gap++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (status[11] === 1'b1) busy++;
      if (i < 4) begin
        if (tx !== 1'b0) ok = 1'b0;
      end else if (i >= 36) begin
        if (tx !== 1'b1) ok = 1'b0;
      end else if (i % 4 == 0) begin
        d[(i-4)/4] = tx;
      end else if (tx !== d[(i-4)/4]) begin
        ok = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    tog    = ~tog;
    io_out = {23'h0, tog, b};
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (status[8] !== tog && w < 200);
    n_vec++;
    if (status[8] !== tog) begin
      n_err++;
      $display("FAIL send_ack byte=%h ack=%b required=%b", b, status[8], tog);
    end
  endtask

  task automatic test_reset;
    int bad;
    rstn   = 1'b0;
    io_out = 32'h0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (status !== 32'h0000_0400 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold status=%h tx=%b required=00000400/1", status, tx);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (status !== 32'h0000_0400) begin
      n_err++;
      $display("FAIL reset_release status=%h required=00000400", status);
    end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || status !== 32'h0000_0400) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_idle bad_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_single;
    logic [7:0] d;
    int gap, busy;
    bit ok;
    tog    = 1'b1;
    io_out = 32'h155;
    @(negedge clk);
    n_vec++;
    if (status !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL single_ack status=%h required=00000100", status);
    end
    recv_frame(d, gap, busy, ok);
    n_vec++;
    if (!ok || d !== 8'h55 || gap != 0) begin
      n_err++;
      $display("FAIL single_frame ok=%0d data=%h gap=%0d required=1/55/0", ok, d, gap);
    end
    n_vec++;
    if (busy != 40) begin
      n_err++;
      $display("FAIL single_busy cycles=%0d required=40", busy);
    end
    @(negedge clk);
    n_vec++;
    if (status !== 32'h0000_0500 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL single_done status=%h tx=%b required=00000500/1", status, tx);
    end
  endtask

  task automatic test_back_to_back;
    fork
      begin
        for (int b = 1; b <= 6; b++) begin
          int w;
          tog    = ~tog;
          io_out = {23'h0, tog, 8'(b)};
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (status[8] !== tog && w < 200);
          n_vec++;
          if (status[8] !== tog) begin
            n_err++;
            $display("FAIL b2b_ack byte=%0d ack=%b required=%b", b, status[8], tog);
          end
          if (b == 5) begin
            n_vec++;
            if (status[9] !== 1'b1) begin
              n_err++;
              $display("FAIL b2b_full full=%b required=1", status[9]);
            end
          end
          if (b == 6) begin
            n_vec++;
            if (w != 37) begin
              n_err++;
              $display("FAIL b2b_pending wait=%0d required=37", w);
            end
            n_vec++;
            if (status[9] !== 1'b1 || status[11] !== 1'b1) begin
              n_err++;
              $display("FAIL pushpop_full full=%b busy=%b required=1/1", status[9], status[11]);
            end
          end
        end
      end
      begin
        for (int k = 1; k <= 6; k++) begin
          logic [7:0] d;
          int gap, busy;
          bit ok;
          recv_frame(d, gap, busy, ok);
          n_vec++;
          if (!ok || d !== 8'(k)) begin
            n_err++;
            $display("FAIL b2b_frame k=%0d ok=%0d data=%h required=%h", k, ok, d, 8'(k));
          end
          if (k > 1) begin
            n_vec++;
            if (gap != 0) begin
              n_err++;
              $display("FAIL b2b_gap k=%0d gap=%0d required=0", k, gap);
            end
          end
        end
      end
    join
    @(negedge clk);
    n_vec++;
    if (status !== 32'h0000_0500) begin
      n_err++;
      $display("FAIL b2b_done status=%h required=00000500", status);
    end
  endtask

  task automatic test_retoggle;
    logic [7:0] d;
    int gap, busy, bad;
    bit ok;
    for (int r = 0; r < 2; r++) begin
      send_byte(8'hA5);
      recv_frame(d, gap, busy, ok);
      n_vec++;
      if (!ok || d !== 8'hA5) begin
        n_err++;
        $display("FAIL retoggle_frame r=%0d ok=%0d data=%h required=a5", r, ok, d);
      end
    end
    bad = 0;
    io_out = {23'h5A5A5A, tog, 8'h3C};
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || status[11] !== 1'b0) bad++;
    end
    io_out[7:0] = 8'hC3;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || status[11] !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0 || status !== 32'h0000_0500) begin
      n_err++;
      $display("FAIL no_toggle bad_cycles=%0d status=%h required=0/00000500", bad, status);
    end
  endtask

  task automatic test_reset_abort;
    int bad;
    io_out = {23'h0, tog, 8'h00};
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (13) @(negedge clk);
    n_vec++;
    if (tx !== 1'b0 || status[11] !== 1'b1 || status[10] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_midframe tx=%b status=%h required=0 busy nonempty", tx, status);
    end
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1 || status !== 32'h0000_0400) begin
      n_err++;
      $display("FAIL abort_async tx=%b status=%h required=1/00000400", tx, status);
    end
    io_out = 32'h0;
    tog    = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || status !== 32'h0000_0400) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_after bad_cycles=%0d required=0", bad);
    end
  endtask

  initial begin
    rstn   = 1'b0;
    io_out = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_retoggle();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
